// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//   Constants shared by the GPIO input path (conditioner, gpiomem, top level),
//   plus a helper that sizes the debounce counters.
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam int N_BUTTONS_DEF   = 4;
  localparam int N_SWITCHES_DEF  = 16;
  localparam int DB_CYCLES_DEF   = 1_000_000;  // 10 ms at 100 MHz
  localparam int SYNC_STAGES_DEF = 2;

  // Width of a counter that must reach db-1. A one-cycle debounce still needs
  // a 1-bit vector so the declaration stays legal.
  function automatic int cnt_width(input int db);
    return (db > 1) ? $clog2(db) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One GPIO input: SYNC_STAGES-flop metastability synchroniser, followed by a
//   stability counter. The stable level q follows the synchronised input only
//   after it has differed from q for DB_CYCLES consecutive cycles.
//
// Ports
//   clk_100MHz  in   system clock
//   rst         in   synchronous, active-low reset
//   din         in   asynchronous raw pin
//   q           out  debounced level
// -----------------------------------------------------------------------------
module debounce_channel
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic din,
  output logic q
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchroniser chain
  // into a single flop.
  always_ff @(posedge clk_100MHz) begin
    if (!rst) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (s == q) begin
        // Any return to the stable level discards the partial count, which is
        // what rejects short glitches and bounce.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        q   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
//   Synchronises and debounces the board push-buttons and slide switches ahead
//   of gpiomem. Buttons additionally get a one-cycle press pulse and a sticky
//   press flag that holds until gpiomem writes 1 to clear it, so cores polling
//   over the shared bus never miss a press.
//
// Ports
//   clk_100MHz     in   system clock, the only clock
//   rst            in   synchronous, active-low reset
//   buttons_raw    in   [N_BUTTONS]  raw button pins, 1 = pressed
//   switches_raw   in   [N_SWITCHES] raw switch pins
//   clr_sticky     in   [N_BUTTONS]  write-1-to-clear for button_sticky
//   buttons        out  [N_BUTTONS]  debounced button levels
//   switches       out  [N_SWITCHES] debounced switch levels
//   button_press   out  [N_BUTTONS]  1-cycle pulse on debounced 0->1 edge
//   button_sticky  out  [N_BUTTONS]  latched press flags
// -----------------------------------------------------------------------------
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int N_BUTTONS     = N_BUTTONS_DEF,
  parameter int N_SWITCHES    = N_SWITCHES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int BTN_DB_CYCLES = DB_CYCLES_DEF,
  parameter int SW_DB_CYCLES  = DB_CYCLES_DEF
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  input  logic [N_BUTTONS-1:0]  buttons_raw,
  input  logic [N_SWITCHES-1:0] switches_raw,
  input  logic [N_BUTTONS-1:0]  clr_sticky,
  output logic [N_BUTTONS-1:0]  buttons,
  output logic [N_SWITCHES-1:0] switches,
  output logic [N_BUTTONS-1:0]  button_press,
  output logic [N_BUTTONS-1:0]  button_sticky
);

  logic [N_BUTTONS-1:0] buttons_prev;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (BTN_DB_CYCLES)
    ) u_db (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .din        (buttons_raw[i]),
      .q          (buttons[i])
    );
  end

  for (genvar i = 0; i < N_SWITCHES; i++) begin : g_sw
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (SW_DB_CYCLES)
    ) u_db (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .din        (switches_raw[i]),
      .q          (switches[i])
    );
  end

  // Both operands are flops, so the pulse is glitch-free and lands in the
  // cycle right after the debounced level rises.
  assign button_press = buttons & ~buttons_prev;

  always_ff @(posedge clk_100MHz) begin
    if (!rst) begin
      buttons_prev  <= '0;
      button_sticky <= '0;
    end else begin
      buttons_prev  <= buttons;
      // Set is OR-ed in after the clear so a press coinciding with a clear
      // survives; the poller sees it on its next read.
      button_sticky <= (button_sticky & ~clr_sticky) | button_press;
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
//   Directed table of vectors and hand-written corner sequences, followed by
//   randomized stimulus. A behavioural model (raw-sample history, windowed
//   stability test) is checked against the DUT after every clock edge.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;

  localparam int SS   = 2;
  localparam int DB   = 8;
  localparam int NB   = 4;
  localparam int NS   = 16;
  localparam int NC   = NB + NS;
  localparam int MAXE = 8192;

  logic          clk_100MHz = 1'b0;
  logic          rst        = 1'b0;
  logic [NB-1:0] buttons_raw  = '0;
  logic [NS-1:0] switches_raw = '0;
  logic [NB-1:0] clr_sticky   = '0;
  logic [NB-1:0] buttons;
  logic [NS-1:0] switches;
  logic [NB-1:0] button_press;
  logic [NB-1:0] button_sticky;

  gpio_input_conditioner #(
    .N_BUTTONS     (NB),
    .N_SWITCHES    (NS),
    .SYNC_STAGES   (SS),
    .BTN_DB_CYCLES (DB),
    .SW_DB_CYCLES  (DB)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .rst           (rst),
    .buttons_raw   (buttons_raw),
    .switches_raw  (switches_raw),
    .clr_sticky    (clr_sticky),
    .buttons       (buttons),
    .switches      (switches),
    .button_press  (button_press),
    .button_sticky (button_sticky)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Channel bits: [NB-1:0] buttons, [NC-1:NB] switches.
  // The synchronised value seen at edge k is the raw value sampled SS edges
  // earlier. A channel adopts the opposite level at edge k when every
  // synchronised sample in the last DB edges (all since its last reset or
  // change) disagreed with its current level.
  // ---------------------------------------------------------------------------
  logic [NC-1:0] raw_hist [SS];
  logic [NC-1:0] s_hist   [MAXE];
  int            last_evt [NC];
  int            edge_n = 0;
  logic [NC-1:0] m_q      = '0;
  logic [NB-1:0] m_press  = '0;
  logic [NB-1:0] m_sticky = '0;

  initial begin
    for (int i = 0; i < SS; i++) raw_hist[i] = '0;
    for (int c = 0; c < NC; c++) last_evt[c] = 0;
  end

  task automatic model_edge();
    logic [NC-1:0] s;
    logic [NC-1:0] old_q;
    bit            all_diff;
    if (!rst) begin
      for (int i = 0; i < SS; i++) raw_hist[i] = '0;
      for (int c = 0; c < NC; c++) last_evt[c] = edge_n;
      m_q      = '0;
      m_press  = '0;
      m_sticky = '0;
    end else begin
      s = raw_hist[SS-1];
      for (int i = SS-1; i > 0; i--) raw_hist[i] = raw_hist[i-1];
      raw_hist[0] = {switches_raw, buttons_raw};
      s_hist[edge_n] = s;
      old_q = m_q;
      for (int c = 0; c < NC; c++) begin
        if (edge_n - last_evt[c] >= DB) begin
          all_diff = 1'b1;
          for (int j = edge_n - DB + 1; j <= edge_n; j++)
            if (s_hist[j][c] == old_q[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_q[c]      = ~old_q[c];
            last_evt[c] = edge_n;
          end
        end
      end
      m_sticky = (m_sticky & ~clr_sticky) | m_press;
      m_press  = m_q[NB-1:0] & ~old_q[NB-1:0];
    end
    edge_n++;
  endtask

  // One clock: inputs are already stable, model steps on the edge, outputs
  // are compared 1 ns later.
  task automatic tick();
    @(posedge clk_100MHz);
    model_edge();
    #1;
    check("mdl_buttons",  32'(buttons),       32'(m_q[NB-1:0]));
    check("mdl_switches", 32'(switches),      32'(m_q[NC-1:NB]));
    check("mdl_press",    32'(button_press),  32'(m_press));
    check("mdl_sticky",   32'(button_sticky), 32'(m_sticky));
  endtask

  typedef struct {
    logic          rst_v;
    logic [NB-1:0] btn;
    logic [NS-1:0] sw;
    logic [NB-1:0] clr;
    int            ticks;
    logic [NB-1:0] e_btn;
    logic [NB-1:0] e_press;
    logic [NB-1:0] e_sticky;
    logic [NS-1:0] e_sw;
  } vec_t;

  vec_t tbl[$];

  int rise_at;
  int n_pulse;
  int hold;

  initial begin
    // rst, btn, sw, clr, ticks | buttons, press, sticky, switches
    // Reset with buttons held high, then outputs rise SS+DB edges later.
    tbl.push_back('{1'b0, 4'hF, 16'h0000, 4'h0, 3,  4'h0, 4'h0, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'hF, 16'h0000, 4'h0, 9,  4'h0, 4'h0, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'hF, 16'h0000, 4'h0, 1,  4'hF, 4'hF, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'hF, 16'h0000, 4'h0, 1,  4'hF, 4'h0, 4'hF, 16'h0000});
    // Glitch on button 0 shorter than DB.
    tbl.push_back('{1'b0, 4'h0, 16'h0000, 4'h0, 3,  4'h0, 4'h0, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'h1, 16'h0000, 4'h0, 5,  4'h0, 4'h0, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'h0, 16'h0000, 4'h0, 12, 4'h0, 4'h0, 4'h0, 16'h0000});
    // Press and release of button 1; no pulse on release.
    tbl.push_back('{1'b1, 4'h2, 16'h0000, 4'h0, 10, 4'h2, 4'h2, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'h2, 16'h0000, 4'h0, 1,  4'h2, 4'h0, 4'h2, 16'h0000});
    tbl.push_back('{1'b1, 4'h0, 16'h0000, 4'h0, 9,  4'h2, 4'h0, 4'h2, 16'h0000});
    tbl.push_back('{1'b1, 4'h0, 16'h0000, 4'h0, 1,  4'h0, 4'h0, 4'h2, 16'h0000});
    tbl.push_back('{1'b1, 4'h0, 16'h0000, 4'h0, 2,  4'h0, 4'h0, 4'h2, 16'h0000});
    // Switches, with a reset landing mid-count.
    tbl.push_back('{1'b1, 4'h0, 16'hA5C3, 4'h0, 6,  4'h0, 4'h0, 4'h2, 16'h0000});
    tbl.push_back('{1'b0, 4'h0, 16'hA5C3, 4'h0, 2,  4'h0, 4'h0, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'h0, 16'hA5C3, 4'h0, 9,  4'h0, 4'h0, 4'h0, 16'h0000});
    tbl.push_back('{1'b1, 4'h0, 16'hA5C3, 4'h0, 1,  4'h0, 4'h0, 4'h0, 16'hA5C3});

    foreach (tbl[i]) begin
      rst          = tbl[i].rst_v;
      buttons_raw  = tbl[i].btn;
      switches_raw = tbl[i].sw;
      clr_sticky   = tbl[i].clr;
      repeat (tbl[i].ticks) tick();
      check($sformatf("row%0d_buttons", i),  32'(buttons),       32'(tbl[i].e_btn));
      check($sformatf("row%0d_press", i),    32'(button_press),  32'(tbl[i].e_press));
      check($sformatf("row%0d_sticky", i),   32'(button_sticky), 32'(tbl[i].e_sticky));
      check($sformatf("row%0d_switches", i), 32'(switches),      32'(tbl[i].e_sw));
    end

    // Bouncy press on button 2: four 3-cycle toggles, then a final rise held.
    for (int k = 0; k < 4; k++) begin
      buttons_raw[2] = ~buttons_raw[2];
      repeat (3) tick();
    end
    buttons_raw[2] = 1'b1;
    rise_at = -1;
    n_pulse = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (buttons[2] && rise_at < 0) rise_at = t;
      if (button_press[2]) n_pulse++;
    end
    check("bouncy_rise_cycle", 32'(rise_at), 32'd10);
    check("bouncy_pulses",     32'(n_pulse), 32'd1);

    // Sticky clear, then clear colliding with a fresh press on button 3.
    buttons_raw = 4'b1100;
    repeat (11) tick();
    check("clr_sticky_before", 32'(button_sticky), 32'h0000_000C);
    clr_sticky = 4'b1000;
    tick();
    clr_sticky = 4'b0000;
    check("clr_sticky_after", 32'(button_sticky), 32'h0000_0004);
    buttons_raw = 4'b0100;
    repeat (10) tick();
    check("clr_release_btn3", 32'(buttons), 32'h0000_0004);
    buttons_raw = 4'b1100;
    repeat (10) tick();
    check("collide_press", 32'(button_press), 32'h0000_0008);
    clr_sticky = 4'b1000;
    tick();
    clr_sticky = 4'b0000;
    check("collide_sticky", 32'(button_sticky), 32'h0000_000C);

    // Randomized stimulus: short and long holds, random clears, rare resets.
    hold = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold == 0) begin
        buttons_raw  = buttons_raw ^ NB'($urandom & $urandom);
        switches_raw = switches_raw ^ NS'($urandom & $urandom);
        hold         = $urandom_range(1, 14);
      end
      hold--;
      clr_sticky = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      rst        = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
